vga_frame_reader: RTL and testbench

Parametrised VGA scan-out engine: generates VGA timing from the system clock, streams pixel addresses to an external frame memory (boid memory or any indexed framebuffer), maps returned multi-bit pixel codes through a writable colour palette and drives aligned RGB/sync outputs. It adds configurable resolution and porches, a pixel clock enable instead of a derived clock, integer pixel upscaling, multi-bit pixels and a pipeline that keeps syncs aligned with colour. It sits between the boid memory read port and the board VGA pins. `screen_end` is the frame-boundary strobe used to update boid memory.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_scan_counters.sv | 70 +++++++
 rtl/vga_frame_reader.sv | 122 ++++++++++++
 tb/tb_vga_frame_reader.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA scan-out engine: 640x480@60 timing defaults,
// colour width and the palette contents loaded on reset.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int COLOR_W = 12;
  typedef logic [COLOR_W-1:0] rgb_t;

  localparam rgb_t PAL_ENTRY0_DEF = 12'h000;
  localparam rgb_t PAL_OTHERS_DEF = 12'hFFF;

  // Entry 0 is the background (black); everything else starts white.
  function automatic rgb_t pal_reset_value(input int idx);
    return (idx == 0) ? PAL_ENTRY0_DEF : PAL_OTHERS_DEF;
  endfunction

endpackage

// File: rtl/vga_scan_counters.sv
// Pixel-tick divider plus x/y raster counters with active, sync and
// line/frame-end decode. All scan state moves only on the tick.
module vga_scan_counters
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       o_tick,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_active,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_line_end,
  output logic       o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             w_tick;
  logic             w_line_end;
  logic             w_frame_end;

  assign w_tick      = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_line_end  = w_tick && (r_x == 10'(H_TOTAL - 1));
  assign w_frame_end = w_line_end && (r_y == 10'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_line_end) begin
        r_x <= '0;
        r_y <= w_frame_end ? '0 : r_y + 1'b1;
      end else if (w_tick) begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_tick      = w_tick;
  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_active    = (r_x < 10'(H_ACTIVE)) && (r_y < 10'(V_ACTIVE));
  assign o_hsync_n   = !((r_x >= 10'(H_ACTIVE + H_FP)) &&
                         (r_x <  10'(H_ACTIVE + H_FP + H_SYNC)));
  assign o_vsync_n   = !((r_y >= 10'(V_ACTIVE + V_FP)) &&
                         (r_y <  10'(V_ACTIVE + V_FP + V_SYNC)));
  assign o_line_end  = w_line_end;
  assign o_frame_end = w_frame_end;

endmodule

// File: rtl/vga_frame_reader.sv
// VGA scan-out: multiplier-free framebuffer addressing with integer upscale,
// writable palette and a two-stage pipeline keeping syncs aligned with colour.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int CLK_DIV    = 4,
  parameter int RD_LATENCY = 1,
  parameter int SCALE_LOG2 = 0,
  parameter int PIX_BITS   = 1,
  parameter int ADDR_W     = $clog2((H_ACTIVE >> SCALE_LOG2) * (V_ACTIVE >> SCALE_LOG2))
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [PIX_BITS-1:0] rd_data,
  input  logic                pal_we,
  input  logic [PIX_BITS-1:0] pal_addr,
  input  logic [COLOR_W-1:0]  pal_data,
  output logic                hSync,
  output logic                vSync,
  output logic [3:0]          VGA_R,
  output logic [3:0]          VGA_G,
  output logic [3:0]          VGA_B,
  output logic                screen_end,
  output logic [9:0]          x_pos,
  output logic [9:0]          y_pos
);

  localparam int FB_W = H_ACTIVE >> SCALE_LOG2;
  localparam int NPAL = 1 << PIX_BITS;

  if (CLK_DIV < 2 || RD_LATENCY >= CLK_DIV) begin : g_bad_cfg
    $error("vga_frame_reader: need CLK_DIV >= 2 and RD_LATENCY < CLK_DIV");
  end

  logic       w_tick, w_active, w_hsync_n, w_vsync_n, w_line_end, w_frame_end;
  logic [9:0] w_x, w_y;
  logic       w_row_last;

  vga_scan_counters #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .o_tick     (w_tick),
    .o_x        (w_x),
    .o_y        (w_y),
    .o_active   (w_active),
    .o_hsync_n  (w_hsync_n),
    .o_vsync_n  (w_vsync_n),
    .o_line_end (w_line_end),
    .o_frame_end(w_frame_end)
  );

  // A framebuffer row spans 2^SCALE_LOG2 scan lines; advance on the last of them.
  if (SCALE_LOG2 == 0) begin : g_row_noscale
    assign w_row_last = 1'b1;
  end else begin : g_row_scale
    assign w_row_last = &w_y[SCALE_LOG2-1:0];
  end

  logic [ADDR_W-1:0]     r_row_base, r_rd_addr;
  logic                  r_act_d, r_hs_d, r_vs_d;
  logic                  r_hsync, r_vsync;
  rgb_t                  r_rgb;
  rgb_t [NPAL-1:0]       r_pal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPAL; i++) r_pal[i] <= pal_reset_value(i);
    end else if (pal_we) begin
      r_pal[pal_addr] <= pal_data;
    end
  end

  // Stage 0 issues the address and delays active/syncs; stage 1 looks up colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_base <= '0;
      r_rd_addr  <= '0;
      r_act_d    <= 1'b0;
      r_hs_d     <= 1'b1;
      r_vs_d     <= 1'b1;
      r_rgb      <= '0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
    end else if (w_tick) begin
      if (w_active) r_rd_addr <= r_row_base + ADDR_W'(w_x >> SCALE_LOG2);
      if (w_frame_end)
        r_row_base <= '0;
      else if (w_line_end && w_row_last && (w_y < 10'(V_ACTIVE)))
        r_row_base <= r_row_base + ADDR_W'(FB_W);
      r_act_d <= w_active;
      r_hs_d  <= w_hsync_n;
      r_vs_d  <= w_vsync_n;
      r_rgb   <= r_act_d ? r_pal[rd_data] : '0;
      r_hsync <= r_hs_d;
      r_vsync <= r_vs_d;
    end
  end

  assign rd_addr    = r_rd_addr;
  assign hSync      = r_hsync;
  assign vSync      = r_vsync;
  assign VGA_R      = r_rgb[11:8];
  assign VGA_G      = r_rgb[7:4];
  assign VGA_B      = r_rgb[3:0];
  assign screen_end = w_frame_end;
  assign x_pos      = w_x;
  assign y_pos      = w_y;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench on a shrunken raster (16x10 ticks, 8x6 visible, 2x upscale,
// 2-bit pixels); frame memory returns the low two address bits.
module tb_vga_frame_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rd_addr;
  logic [1:0]  rd_data = 2'd0;
  logic        pal_we = 1'b0;
  logic [1:0]  pal_addr = 2'd0;
  logic [11:0] pal_data = 12'h000;
  logic        hSync, vSync, screen_end;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic [9:0]  x_pos, y_pos;

  int checks = 0;
  int failures = 0;
  int n_clk = 0;

  vga_frame_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(4), .RD_LATENCY(1), .SCALE_LOG2(1), .PIX_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .hSync(hSync), .vSync(vSync), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .screen_end(screen_end), .x_pos(x_pos), .y_pos(y_pos)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rd_addr[1:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to the negedge following posedge number t since reset release.
  task automatic goto_clk(input int t);
    if (t > n_clk) begin
      repeat (t - n_clk) @(posedge clk);
      n_clk = t;
      @(negedge clk);
    end
  endtask

  task automatic vec(input int kk, input int e_rd, input int e_rgb, input int e_hs,
                     input int e_vs, input int e_x, input int e_y);
    goto_clk(4 * kk);
    chk($sformatf("k%0d_rd_addr", kk), 32'(rd_addr), e_rd);
    chk($sformatf("k%0d_rgb", kk), 32'({VGA_R, VGA_G, VGA_B}), e_rgb);
    chk($sformatf("k%0d_hsync", kk), 32'(hSync), e_hs);
    chk($sformatf("k%0d_vsync", kk), 32'(vSync), e_vs);
    chk($sformatf("k%0d_x_pos", kk), 32'(x_pos), e_x);
    chk($sformatf("k%0d_y_pos", kk), 32'(y_pos), e_y);
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_hsync"}, 32'(hSync), 1);
    chk({tag, "_vsync"}, 32'(vSync), 1);
    chk({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_screen_end"}, 32'(screen_end), 0);
    chk({tag, "_x_pos"}, 32'(x_pos), 0);
    chk({tag, "_y_pos"}, 32'(y_pos), 0);
  endtask

  initial begin
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_reset_pins("rst");
    $display("step reset_hold: reset values checked");

    reset = 1'b0;
    n_clk = 0;
    pal_we = 1'b1; pal_addr = 2'd1; pal_data = 12'h00F;
    goto_clk(1);
    pal_addr = 2'd2; pal_data = 12'h0F0;
    goto_clk(2);
    pal_addr = 2'd3; pal_data = 12'hF00;
    goto_clk(3);
    pal_we = 1'b0;
    chk("pre_first_tick_x", 32'(x_pos), 0);
    goto_clk(4);
    chk("first_tick_x", 32'(x_pos), 1);
    $display("step first_tick: x_pos=%0d after 4 clk", x_pos);

    // kk = tick count; pins show raster position kk-2, rd_addr position kk-1.
    vec(2,   0,  12'h000, 1, 1, 2,  0);
    vec(4,   1,  12'h00F, 1, 1, 4,  0);
    vec(6,   2,  12'h0F0, 1, 1, 6,  0);
    vec(8,   3,  12'hF00, 1, 1, 8,  0);
    vec(10,  3,  12'h000, 1, 1, 10, 0);
    vec(12,  3,  12'h000, 0, 1, 12, 0);
    vec(14,  3,  12'h000, 0, 1, 14, 0);
    vec(15,  3,  12'h000, 1, 1, 15, 0);
    vec(18,  0,  12'h000, 1, 1, 2,  1);
    vec(36,  5,  12'h00F, 1, 1, 4,  2);
    vec(56,  7,  12'hF00, 1, 1, 8,  3);
    vec(86,  10, 12'h0F0, 1, 1, 6,  5);
    vec(114, 11, 12'h000, 1, 0, 2,  7);
    vec(124, 11, 12'h000, 0, 0, 12, 7);
    vec(146, 11, 12'h000, 1, 1, 2,  9);
    $display("step frame0: line/vertical timing and addressing checked");

    goto_clk(638);
    chk("se_before", 32'(screen_end), 0);
    goto_clk(639);
    chk("se_pulse", 32'(screen_end), 1);
    vec(160, 11, 12'h000, 1, 1, 0, 0);
    chk("se_after", 32'(screen_end), 0);
    vec(164, 1,  12'h00F, 1, 1, 4, 0);
    vec(166, 2,  12'h0F0, 1, 1, 6, 0);
    $display("step frame_wrap: screen_end and row_base wrap checked");

    pal_we = 1'b1; pal_addr = 2'd2; pal_data = 12'hFFF;
    goto_clk(665);
    pal_we = 1'b0;
    chk("pal_mid_pixel", 32'({VGA_R, VGA_G, VGA_B}), 12'h0F0);
    vec(167, 3, 12'hFFF, 1, 1, 7, 0);
    vec(168, 3, 12'hF00, 1, 1, 8, 0);
    $display("step palette_write: update lands on next tick");

    vec(230, 10, 12'hFFF, 1, 1, 6, 4);
    reset = 1'b1;
    #1;
    chk_reset_pins("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_clk = 0;
    $display("step mid_reset: async clear checked");

    vec(2, 0, 12'h000, 1, 1, 2, 0);
    vec(4, 1, 12'hFFF, 1, 1, 4, 0);
    goto_clk(638);
    chk("se2_before", 32'(screen_end), 0);
    goto_clk(639);
    chk("se2_pulse", 32'(screen_end), 1);
    goto_clk(640);
    chk("se2_after", 32'(screen_end), 0);
    chk("se2_x_wrap", 32'(x_pos), 0);
    chk("se2_y_wrap", 32'(y_pos), 0);
    $display("step restart: frame period after reset checked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
